// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM input capture unit.
//   state_e  - capture FSM states
//   FLG_CAP  - flag/intr bit index for capture done
//   FLG_OVF  - flag/intr bit index for counter overflow
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_e;

    localparam int unsigned FLG_CAP = 0;
    localparam int unsigned FLG_OVF = 1;

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an asynchronous input, optional
// inversion, and single-cycle rise/fall pulses on the synchronised level.
//   pclk, presetn - clock, asynchronous active-low reset
//   din           - asynchronous input
//   inv           - invert the synchronised level
//   level         - synchronised (and optionally inverted) level
//   rise, fall    - one-cycle pulses on level transitions
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic presetn,
    input  logic din,
    input  logic inv,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync_q    <= '0;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
            level_d_q <= level;
        end
    end

    assign level = sync_q[SYNC_STAGES-1] ^ inv;
    assign rise  = level & ~level_d_q;
    assign fall  = ~level & level_d_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in
// prescaled ticks, with sticky capture-done / overflow flags and interrupts.
//   pclk, presetn        - clock, asynchronous active-low reset
//   en                   - enable capture
//   pwm_in, inv          - PWM input and post-synchroniser inversion
//   prescale             - tick every prescale+1 pclk cycles
//   intr_en, flag_clr    - interrupt enables, write-1-to-clear flag pulses
//   high_time, period    - last captured values
//   flag, intr, busy     - sticky flags, gated interrupts, measuring status
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             en,
    input  logic             pwm_in,
    input  logic             inv,
    input  logic [7:0]       prescale,
    input  logic [1:0]       intr_en,
    input  logic [1:0]       flag_clr,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       flag,
    output logic [1:0]       intr,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [7:0]       pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [1:0]       flag_q, flag_d;
    logic [1:0]       flag_set;

    logic             level, rise, fall;
    logic             tick, measuring, ovf;
    logic [CNT_W:0]   cnt_inc;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .pclk   (pclk),
        .presetn(presetn),
        .din    (pwm_in),
        .inv    (inv),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    assign measuring = (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
    assign tick      = (pre_q == prescale);
    // One extra bit so the carry out marks a tick landing on a full counter.
    assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, tick};
    assign ovf       = measuring && cnt_inc[CNT_W];

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (en) state_d = WAIT_RISE;
            WAIT_RISE: if (rise) state_d = MEAS_HIGH;
            MEAS_HIGH: begin
                if (ovf)       state_d = WAIT_RISE;
                else if (fall) state_d = MEAS_LOW;
            end
            MEAS_LOW: begin
                if (ovf)       state_d = WAIT_RISE;
                else if (rise) state_d = MEAS_HIGH;
            end
            default:   state_d = IDLE;
        endcase
        if (!en) state_d = IDLE;
    end

    // Outputs
    always_comb begin
        busy = measuring;
        intr = intr_en & flag_q;
    end

    // Datapath next-state: prescaler, counter, latches and flag sets
    always_comb begin
        pre_d       = pre_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        flag_set    = '0;
        if (!en || !measuring) begin
            // Idle or waiting: hold the measurement machinery at zero so a
            // rise starts from a clean prescaler phase.
            pre_d = '0;
            cnt_d = '0;
        end else begin
            pre_d = tick ? 8'd0 : pre_q + 8'd1;
            cnt_d = cnt_inc[CNT_W-1:0];
            if (ovf) begin
                flag_set[FLG_OVF] = 1'b1;
                cnt_d             = '0;
                pre_d             = '0;
            end else if (state_q == MEAS_HIGH && fall) begin
                hi_lat_d = cnt_inc[CNT_W-1:0];
            end else if (state_q == MEAS_LOW && rise) begin
                period_d          = cnt_inc[CNT_W-1:0];
                high_time_d       = hi_lat_q;
                flag_set[FLG_CAP] = 1'b1;
                cnt_d             = '0;
                pre_d             = '0;
            end
        end
        // Set beats a coincident clear.
        flag_d = (flag_q & ~flag_clr) | flag_set;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pre_q       <= '0;
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            flag_q      <= '0;
        end else begin
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            hi_lat_q    <= hi_lat_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            flag_q      <= flag_d;
        end
    end

    assign high_time = high_time_q;
    assign period    = period_q;
    assign flag      = flag_q;

endmodule
